// File: rtl/rvfi_retire_packer.sv
// ============================================================================
// rvfi_retire_packer
//
// Purpose:
//   Producer side of the RVFI retirement stream. Instruction slots are
//   allocated in program order and completed in any order. Up to NRET
//   completed instructions per cycle are retired strictly in program order
//   onto registered RVFI channels, each stamped with a monotonically
//   increasing rvfi_order.
//
// Parameters:
//   NRET   RVFI channels emitted per cycle
//   DEPTH  buffer entries (power of two, >= 2)
//   XLEN   data width
//   TW     tag width, $clog2(DEPTH) (derived)
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   flush                   (only with RVFI_PACKER_FLUSH_EN) drop all
//                           unretired entries after this cycle's retirement
//   alloc_valid/ready/tag   program-order slot allocation; tag is the slot
//                           granted this cycle
//   cmpl_*                  completion strobe, slot tag and retire payload
//   rvfi_valid/order/insn/rs1_addr/rs2_addr/rd_addr/rd_wdata
//                           registered retirement channels, channel c at
//                           slice c of each packed bus
//
// Optional feature macro:
//   RVFI_PACKER_FLUSH_EN    adds the flush input and its logic
// ============================================================================
module rvfi_retire_packer #(
    parameter  int NRET  = 2,
    parameter  int DEPTH = 8,
    parameter  int XLEN  = 32,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef RVFI_PACKER_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    output logic [TW-1:0]        alloc_tag,
    input  logic                 cmpl_valid,
    input  logic [TW-1:0]        cmpl_tag,
    input  logic [31:0]          cmpl_insn,
    input  logic [4:0]           cmpl_rs1_addr,
    input  logic [4:0]           cmpl_rs2_addr,
    input  logic [4:0]           cmpl_rd_addr,
    input  logic [XLEN-1:0]      cmpl_rd_wdata,
    output logic [NRET-1:0]      rvfi_valid,
    output logic [64*NRET-1:0]   rvfi_order,
    output logic [32*NRET-1:0]   rvfi_insn,
    output logic [5*NRET-1:0]    rvfi_rs1_addr,
    output logic [5*NRET-1:0]    rvfi_rs2_addr,
    output logic [5*NRET-1:0]    rvfi_rd_addr,
    output logic [XLEN*NRET-1:0] rvfi_rd_wdata
);

    localparam int          KW   = $clog2(NRET + 1);
    localparam logic [TW:0] FULL = (TW + 1)'(DEPTH);

    // Per-entry bookkeeping and completion payload
    logic [DEPTH-1:0] allocQ;
    logic [DEPTH-1:0] allocD;
    logic [DEPTH-1:0] doneQ;
    logic [DEPTH-1:0] doneD;
    logic [31:0]      insnQ  [DEPTH];
    logic [4:0]       rs1Q   [DEPTH];
    logic [4:0]       rs2Q   [DEPTH];
    logic [4:0]       rdQ    [DEPTH];
    logic [XLEN-1:0]  wdataQ [DEPTH];

    // Ring pointers, occupancy and the running instruction index
    logic [TW-1:0] headQ;
    logic [TW-1:0] headD;
    logic [TW-1:0] tailQ;
    logic [TW-1:0] tailD;
    logic [TW:0]   countQ;
    logic [TW:0]   countD;
    logic [63:0]   orderQ;
    logic [63:0]   orderD;

    // Retire selection for the current cycle
    logic [NRET-1:0] retireMask;
    logic [TW-1:0]   retireIdx [NRET];
    logic [KW-1:0]   retireCount;
    logic            retireRun;

    logic grant;
    logic allocWrite;
    logic cmplAccept;
    logic cmplWrite;

    // Registered RVFI channels
    logic [NRET-1:0]      rvfiValidQ;
    logic [64*NRET-1:0]   rvfiOrderQ;
    logic [32*NRET-1:0]   rvfiInsnQ;
    logic [5*NRET-1:0]    rvfiRs1Q;
    logic [5*NRET-1:0]    rvfiRs2Q;
    logic [5*NRET-1:0]    rvfiRdQ;
    logic [XLEN*NRET-1:0] rvfiWdataQ;

    // Space is judged on registered count only, so a slot freed by a
    // retirement this cycle can be granted no earlier than next cycle.
    assign alloc_ready = (countQ != FULL);
    assign alloc_tag   = tailQ;
    assign grant       = alloc_valid && alloc_ready;

    // First completion wins; stray or repeated completions are dropped.
    assign cmplAccept  = cmpl_valid && allocQ[cmpl_tag] && !doneQ[cmpl_tag];

    // A flush swallows any allocation or completion offered alongside it.
`ifdef RVFI_PACKER_FLUSH_EN
    assign allocWrite  = grant && !flush;
    assign cmplWrite   = cmplAccept && !flush;
`else
    assign allocWrite  = grant;
    assign cmplWrite   = cmplAccept;
`endif

    // Walk forward from head while entries are done; the first not-done
    // entry stops the walk so retirement never skips over an instruction.
    // The count bound keeps stale done bits beyond the tail out of reach.
    always_comb begin
        retireRun   = 1'b1;
        retireCount = '0;
        for (int c = 0; c < NRET; c++) begin
            retireIdx[c]  = headQ + TW'(c);
            retireMask[c] = retireRun && (c < int'(countQ)) && doneQ[retireIdx[c]];
            retireRun     = retireMask[c];
            retireCount   = retireCount + KW'(retireMask[c]);
        end
    end

    // Next-state for pointers and entry flags. Retired, newly allocated and
    // newly completed entries can never be the same slot: retirement needs
    // done, completion needs not-done, and the tail slot is free whenever a
    // grant is possible.
    always_comb begin
        allocD = allocQ;
        doneD  = doneQ;
        headD  = headQ + TW'(retireCount);
        orderD = orderQ + 64'(retireCount);
        tailD  = tailQ;
        countD = countQ - (TW + 1)'(retireCount);

        for (int c = 0; c < NRET; c++) begin
            if (retireMask[c]) begin
                allocD[retireIdx[c]] = 1'b0;
                doneD[retireIdx[c]]  = 1'b0;
            end
        end

`ifdef RVFI_PACKER_FLUSH_EN
        // Everything behind this cycle's retirements is discarded; the
        // order counter keeps running so the stream stays monotonic.
        if (flush) begin
            allocD = '0;
            doneD  = '0;
            tailD  = headD;
            countD = '0;
        end
`endif

        if (allocWrite) begin
            allocD[tailQ] = 1'b1;
            doneD[tailQ]  = 1'b0;
            tailD         = tailQ + TW'(1);
            countD        = countD + (TW + 1)'(1);
        end

        if (cmplWrite) begin
            doneD[cmpl_tag] = 1'b1;
        end
    end

    // Completion payload storage. No reset is needed: an entry's payload is
    // only read once its done bit is set, which always follows a write here.
    always_ff @(posedge clock) begin
        if (cmplWrite) begin
            insnQ[cmpl_tag]  <= cmpl_insn;
            rs1Q[cmpl_tag]   <= cmpl_rs1_addr;
            rs2Q[cmpl_tag]   <= cmpl_rs2_addr;
            rdQ[cmpl_tag]    <= cmpl_rd_addr;
            wdataQ[cmpl_tag] <= cmpl_rd_wdata;
        end
    end

    // Control state and registered RVFI channels. Idle channels are driven
    // fully to zero, and x0 writes always report zero data.
    always_ff @(posedge clock) begin
        if (reset) begin
            allocQ     <= '0;
            doneQ      <= '0;
            headQ      <= '0;
            tailQ      <= '0;
            countQ     <= '0;
            orderQ     <= '0;
            rvfiValidQ <= '0;
            rvfiOrderQ <= '0;
            rvfiInsnQ  <= '0;
            rvfiRs1Q   <= '0;
            rvfiRs2Q   <= '0;
            rvfiRdQ    <= '0;
            rvfiWdataQ <= '0;
        end else begin
            allocQ <= allocD;
            doneQ  <= doneD;
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
            orderQ <= orderD;
            for (int c = 0; c < NRET; c++) begin
                if (retireMask[c]) begin
                    rvfiValidQ[c]             <= 1'b1;
                    rvfiOrderQ[64*c +: 64]    <= orderQ + 64'(c);
                    rvfiInsnQ[32*c +: 32]     <= insnQ[retireIdx[c]];
                    rvfiRs1Q[5*c +: 5]        <= rs1Q[retireIdx[c]];
                    rvfiRs2Q[5*c +: 5]        <= rs2Q[retireIdx[c]];
                    rvfiRdQ[5*c +: 5]         <= rdQ[retireIdx[c]];
                    rvfiWdataQ[XLEN*c +: XLEN] <= (rdQ[retireIdx[c]] == 5'd0) ?
                                                  '0 : wdataQ[retireIdx[c]];
                end else begin
                    rvfiValidQ[c]             <= 1'b0;
                    rvfiOrderQ[64*c +: 64]    <= '0;
                    rvfiInsnQ[32*c +: 32]     <= '0;
                    rvfiRs1Q[5*c +: 5]        <= '0;
                    rvfiRs2Q[5*c +: 5]        <= '0;
                    rvfiRdQ[5*c +: 5]         <= '0;
                    rvfiWdataQ[XLEN*c +: XLEN] <= '0;
                end
            end
        end
    end

    assign rvfi_valid    = rvfiValidQ;
    assign rvfi_order    = rvfiOrderQ;
    assign rvfi_insn     = rvfiInsnQ;
    assign rvfi_rs1_addr = rvfiRs1Q;
    assign rvfi_rs2_addr = rvfiRs2Q;
    assign rvfi_rd_addr  = rvfiRdQ;
    assign rvfi_rd_wdata = rvfiWdataQ;

endmodule

// File: tb/tb_rvfi_retire_packer.sv
// ============================================================================
// tb_rvfi_retire_packer
//
// Testbench for rvfi_retire_packer. A program-order queue model predicts
// which instructions retire on which clock edge; predictions go into a
// scoreboard that a negedge monitor drains against the RVFI channels.
// Build with RVFI_PACKER_FLUSH_EN defined to also exercise flush.
// ============================================================================
module tb_rvfi_retire_packer;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int TW    = $clog2(DEPTH);

    logic                 clock;
    logic                 reset;
`ifdef RVFI_PACKER_FLUSH_EN
    logic                 flush;
`endif
    logic                 allocValid;
    logic                 allocReady;
    logic [TW-1:0]        allocTag;
    logic                 cmplValid;
    logic [TW-1:0]        cmplTag;
    logic [31:0]          cmplInsn;
    logic [4:0]           cmplRs1;
    logic [4:0]           cmplRs2;
    logic [4:0]           cmplRd;
    logic [XLEN-1:0]      cmplWdata;
    logic [NRET-1:0]      rvfiValid;
    logic [64*NRET-1:0]   rvfiOrder;
    logic [32*NRET-1:0]   rvfiInsn;
    logic [5*NRET-1:0]    rvfiRs1;
    logic [5*NRET-1:0]    rvfiRs2;
    logic [5*NRET-1:0]    rvfiRd;
    logic [XLEN*NRET-1:0] rvfiWdata;

    rvfi_retire_packer #(
        .NRET (NRET),
        .DEPTH(DEPTH),
        .XLEN (XLEN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef RVFI_PACKER_FLUSH_EN
        .flush        (flush),
`endif
        .alloc_valid  (allocValid),
        .alloc_ready  (allocReady),
        .alloc_tag    (allocTag),
        .cmpl_valid   (cmplValid),
        .cmpl_tag     (cmplTag),
        .cmpl_insn    (cmplInsn),
        .cmpl_rs1_addr(cmplRs1),
        .cmpl_rs2_addr(cmplRs2),
        .cmpl_rd_addr (cmplRd),
        .cmpl_rd_wdata(cmplWdata),
        .rvfi_valid   (rvfiValid),
        .rvfi_order   (rvfiOrder),
        .rvfi_insn    (rvfiInsn),
        .rvfi_rs1_addr(rvfiRs1),
        .rvfi_rs2_addr(rvfiRs2),
        .rvfi_rd_addr (rvfiRd),
        .rvfi_rd_wdata(rvfiWdata)
    );

    // Instruction in flight, in program order
    typedef struct {
        logic [TW-1:0]   tag;
        bit              done;
        logic [31:0]     insn;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } entry_t;

    // Predicted retirement, stamped with the edge it should appear after
    typedef struct {
        int              stamp;
        logic [63:0]     order;
        logic [31:0]     insn;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } expect_t;

    entry_t        modelQ[$];
    expect_t       scoreQ[$];
    logic [TW-1:0] mHead;
    logic [TW-1:0] mTail;
    logic [63:0]   mOrder;

    int checks    = 0;
    int errors    = 0;
    int posCount  = 0;
    bit monEnable = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) posCount <= posCount + 1;

    // One comparison; reports on mismatch
    task automatic checkOutput(input string name, input logic [63:0] actv, input logic [63:0] expv);
        checks++;
        if (actv !== expv) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, posCount, actv, expv);
        end
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then wait
    // until just after that edge.
    task automatic applyStimulus(input bit rst, input bit fl, input bit av, input bit cv,
                                 input logic [TW-1:0] tag, input logic [31:0] insn,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [XLEN-1:0] wd);
        int      k;
        int      hit;
        bit      wasFull;
        entry_t  e;
        expect_t x;

        reset      = rst;
        allocValid = av;
        cmplValid  = cv;
        cmplTag    = tag;
        cmplInsn   = insn;
        cmplRs1    = rs1;
        cmplRs2    = rs2;
        cmplRd     = rd;
        cmplWdata  = wd;
`ifdef RVFI_PACKER_FLUSH_EN
        flush      = fl;
`endif

        if (!rst && monEnable) begin
            checkOutput("alloc_ready", 64'(allocReady), 64'(modelQ.size() != DEPTH));
            checkOutput("alloc_tag", 64'(allocTag), 64'(mTail));
        end

        if (rst) begin
            modelQ.delete();
            mHead  = '0;
            mTail  = '0;
            mOrder = '0;
        end else begin
            wasFull = (modelQ.size() == DEPTH);
            k = 0;
            while (k < NRET && k < modelQ.size() && modelQ[k].done) k++;
            hit = -1;
            if (cv) begin
                for (int i = 0; i < modelQ.size(); i++) begin
                    if (modelQ[i].tag == tag && !modelQ[i].done) hit = i;
                end
            end
            if (!fl && hit >= 0) begin
                e       = modelQ[hit];
                e.done  = 1'b1;
                e.insn  = insn;
                e.rs1   = rs1;
                e.rs2   = rs2;
                e.rd    = rd;
                e.wdata = wd;
                modelQ[hit] = e;
            end
            for (int i = 0; i < k; i++) begin
                e       = modelQ.pop_front();
                x.stamp = posCount + 1;
                x.order = mOrder;
                x.insn  = e.insn;
                x.rs1   = e.rs1;
                x.rs2   = e.rs2;
                x.rd    = e.rd;
                x.wdata = (e.rd == 5'd0) ? '0 : e.wdata;
                scoreQ.push_back(x);
                mOrder++;
                mHead++;
            end
            if (fl) begin
                modelQ.delete();
                mTail = mHead;
            end else if (av && !wasFull) begin
                e       = '{default: '0};
                e.tag   = mTail;
                e.done  = 1'b0;
                modelQ.push_back(e);
                mTail++;
            end
        end

        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic doAlloc();
        applyStimulus(0, 0, 1, 0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic doCmpl(input logic [TW-1:0] tag, input logic [31:0] insn,
                          input logic [4:0] rd, input logic [XLEN-1:0] wd);
        applyStimulus(0, 0, 0, 1, tag, insn, 5'd2, 5'd3, rd, wd);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, '0, '0, '0, '0, '0, '0);
    endtask

    // Monitor: every negedge, pull this edge's predictions off the
    // scoreboard and compare them channel by channel; unused channels must
    // be all-zero.
    always @(negedge clock) begin
        int      n;
        expect_t x;
        if (monEnable) begin
            n = 0;
            while (n < scoreQ.size() && n < NRET && scoreQ[n].stamp == posCount) n++;
            checkOutput("rvfi_valid", 64'(rvfiValid), 64'((1 << n) - 1));
            for (int c = 0; c < NRET; c++) begin
                if (c < n) begin
                    x = scoreQ.pop_front();
                    checkOutput("rvfi_order", rvfiOrder[64*c +: 64], x.order);
                    checkOutput("rvfi_insn", 64'(rvfiInsn[32*c +: 32]), 64'(x.insn));
                    checkOutput("rvfi_regs", 64'({rvfiRs1[5*c +: 5], rvfiRs2[5*c +: 5], rvfiRd[5*c +: 5]}),
                                64'({x.rs1, x.rs2, x.rd}));
                    checkOutput("rvfi_rd_wdata", 64'(rvfiWdata[XLEN*c +: XLEN]), 64'(x.wdata));
                end else begin
                    checkOutput("idle_order", rvfiOrder[64*c +: 64], 64'd0);
                    checkOutput("idle_fields",
                                64'({rvfiInsn[32*c +: 32], rvfiRs1[5*c +: 5], rvfiRs2[5*c +: 5]}) |
                                64'({rvfiRd[5*c +: 5], rvfiWdata[XLEN*c +: XLEN]}), 64'd0);
                end
            end
        end
    end

    initial begin
        bit              rst;
        bit              fl;
        bit              av;
        bit              cv;
        logic [TW-1:0]   tag;
        logic [4:0]      rd;

        doReset();
        monEnable = 1'b1;
        doReset();

        $display("[TB] single instruction");
        doAlloc();
        applyStimulus(0, 0, 0, 1, 3'd0, 32'h0050_0093, 5'd0, 5'd0, 5'd1, 32'd5);
        idle(3);

        $display("[TB] out-of-order completion");
        doReset();
        doAlloc();
        doAlloc();
        doAlloc();
        doCmpl(3'd2, 32'h0000_0213, 5'd4, 32'h22);
        doCmpl(3'd1, 32'h0000_0113, 5'd3, 32'h11);
        doCmpl(3'd0, 32'h0000_0013, 5'd2, 32'h10);
        idle(3);

        $display("[TB] full buffer");
        doReset();
        for (int i = 0; i < DEPTH; i++) doAlloc();
        doAlloc();
        doAlloc();
        idle(1);

        $display("[TB] illegal completions and x0");
        doReset();
        doAlloc();
        doAlloc();
        doCmpl(3'd5, 32'h0000_0513, 5'd7, 32'h55);
        doCmpl(3'd0, 32'h0000_0093, 5'd1, 32'h1111);
        doCmpl(3'd0, 32'h0000_0093, 5'd1, 32'h2222);
        doCmpl(3'd1, 32'h0000_0013, 5'd0, 32'hDEAD);
        idle(3);

        $display("[TB] reset mid-stream");
        doReset();
        doAlloc();
        doAlloc();
        doAlloc();
        doCmpl(3'd2, 32'h1, 5'd5, 32'h3);
        doCmpl(3'd1, 32'h2, 5'd6, 32'h2);
        doCmpl(3'd0, 32'h3, 5'd7, 32'h1);
        doReset();
        doAlloc();
        doCmpl(3'd0, 32'h0070_0393, 5'd7, 32'h7);
        idle(3);

`ifdef RVFI_PACKER_FLUSH_EN
        $display("[TB] flush");
        for (int i = 0; i < 4; i++) doAlloc();
        doCmpl(3'd1, 32'hA, 5'd1, 32'hA);
        doCmpl(3'd3, 32'hB, 5'd2, 32'hB);
        doCmpl(3'd2, 32'hC, 5'd3, 32'hC);
        applyStimulus(0, 1, 1, 1, 3'd4, 32'hD, 5'd0, 5'd0, 5'd4, 32'hD);
        doAlloc();
        doCmpl(mTail - 3'd1, 32'hE, 5'd5, 32'hE);
        idle(3);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            fl  = 1'b0;
`ifdef RVFI_PACKER_FLUSH_EN
            fl  = ($urandom_range(0, 99) == 0);
`endif
            av  = ($urandom_range(0, 3) != 0);
            cv  = ($urandom_range(0, 2) != 0);
            if (modelQ.size() > 0 && $urandom_range(0, 7) != 0)
                tag = modelQ[$urandom_range(0, modelQ.size() - 1)].tag;
            else
                tag = TW'($urandom);
            rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            applyStimulus(rst, fl, av, cv, tag, $urandom, 5'($urandom), 5'($urandom), rd, $urandom);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
